// File: rtl/cosine_controller.sv
// ---------------------------------------------------------------------------
// cosine_controller
//
// Sequencing FSM for the cosine-distance datapath. A trigger in StandBy
// starts one calculation. The calculation runs through Alert (1 cycle),
// StartCalculation (1 cycle) and AccumulateTerms (TERMS cycles, term walks
// 0..TERMS-1). It then waits in CalculateDistance for the datapath's done
// flag. result_valid pulses for the first StandBy cycle after a normal
// completion.
//
// Optional feature (macro COSINE_WATCHDOG_EN):
//   When defined, an 8-bit watchdog bounds the time spent in
//   CalculateDistance to TIMEOUT cycles. On expiry the FSM returns to
//   StandBy, the sticky timeout_err flag is set, and no result is
//   signalled. When undefined, CalculateDistance waits indefinitely and
//   timeout_err is tied low.
//
// Parameters
//   TERMS        series terms accumulated per calculation (1..15)
//   TIMEOUT      watchdog limit in CalculateDistance cycles (1..255)
//
// Ports
//   clk          clock, rising-edge active
//   asyncclear   asynchronous active-high reset
//   trigger      calculation request, sampled only in StandBy
//   abort        synchronous cancel of a calculation in progress
//   done         datapath completion flag, honoured only in CalculateDistance
//   state        current state code (StandBy=0 .. CalculateDistance=4)
//   term         index of the term being accumulated, 0 outside AccumulateTerms
//   alert        high while in Alert
//   busy         high in every state except StandBy
//   result_valid one-cycle pulse when the distance output is final
//   timeout_err  sticky watchdog error flag
// ---------------------------------------------------------------------------
module cosine_controller #(
  parameter int TERMS   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       asyncclear,
  input  logic       trigger,
  input  logic       abort,
  input  logic       done,
  output logic [2:0] state,
  output logic [3:0] term,
  output logic       alert,
  output logic       busy,
  output logic       result_valid,
  output logic       timeout_err
);

  // Elaboration-time range checks on the configuration.
  if (TERMS < 1 || TERMS > 15) begin : gTermsRange
    $error("cosine_controller: TERMS must be in 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : gTimeoutRange
    $error("cosine_controller: TIMEOUT must be in 1..255");
  end

  typedef enum logic [2:0] {
    StandBy           = 3'd0,
    Alert             = 3'd1,
    StartCalculation  = 3'd2,
    AccumulateTerms   = 3'd3,
    CalculateDistance = 3'd4
  } stateT;

  localparam logic [3:0] LastTerm = 4'(TERMS - 1);

  stateT      stateReg;
  stateT      nextState;
  logic [3:0] termReg;
  logic [3:0] nextTerm;
  logic       validReg;
  logic       nextValid;

  // Abort is only meaningful while a calculation is running.
  logic abortActive;
  assign abortActive = abort && (stateReg != StandBy);

`ifdef COSINE_WATCHDOG_EN
  logic [7:0] wdCount;
  logic [7:0] nextWdCount;
  logic       timeoutReg;
  logic       setTimeout;
  logic       wdExpire;

  // The count holds the number of CalculateDistance cycles already
  // completed, so reaching TIMEOUT-1 in the current cycle means this is
  // the TIMEOUT-th cycle spent waiting.
  assign wdExpire = (wdCount == 8'(TIMEOUT - 1));
`endif

  // Next-state, term sequencing and completion decode.
  always_comb begin
    nextState = stateReg;
    nextTerm  = 4'd0;
    nextValid = 1'b0;
`ifdef COSINE_WATCHDOG_EN
    nextWdCount = wdCount;
    setTimeout  = 1'b0;
`endif
    case (stateReg)
      StandBy: begin
        if (trigger) begin
          nextState = Alert;
        end
      end
      Alert: begin
        nextState = StartCalculation;
      end
      StartCalculation: begin
        // term is already 0 here and stays 0 for the first accumulate cycle.
        nextState = AccumulateTerms;
      end
      AccumulateTerms: begin
        if (termReg == LastTerm) begin
          nextState = CalculateDistance;
`ifdef COSINE_WATCHDOG_EN
          nextWdCount = 8'd0;
`endif
        end else begin
          nextTerm = termReg + 4'd1;
        end
      end
      CalculateDistance: begin
        if (done) begin
          nextState = StandBy;
          nextValid = 1'b1;
`ifdef COSINE_WATCHDOG_EN
        end else if (wdExpire) begin
          nextState  = StandBy;
          setTimeout = 1'b1;
        end else begin
          nextWdCount = wdCount + 8'd1;
`endif
        end
      end
      default: begin
        // Unused codes 5..7 recover to StandBy.
        nextState = StandBy;
      end
    endcase

    // Abort overrides every other outcome, including done and watchdog expiry.
    if (abortActive) begin
      nextState = StandBy;
      nextTerm  = 4'd0;
      nextValid = 1'b0;
`ifdef COSINE_WATCHDOG_EN
      setTimeout = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge asyncclear) begin
    if (asyncclear) begin
      stateReg <= StandBy;
      termReg  <= 4'd0;
      validReg <= 1'b0;
    end else begin
      stateReg <= nextState;
      termReg  <= nextTerm;
      validReg <= nextValid;
    end
  end

`ifdef COSINE_WATCHDOG_EN
  always_ff @(posedge clk or posedge asyncclear) begin
    if (asyncclear) begin
      wdCount    <= 8'd0;
      timeoutReg <= 1'b0;
    end else begin
      wdCount <= nextWdCount;
      // Sticky until the next asyncclear; never blocks a new trigger.
      if (setTimeout) begin
        timeoutReg <= 1'b1;
      end
    end
  end

  assign timeout_err = timeoutReg;
`else
  assign timeout_err = 1'b0;
`endif

  // Status outputs decode straight from the state register so that
  // asyncclear takes effect on them without waiting for a clock.
  assign state        = stateReg;
  assign term         = termReg;
  assign alert        = (stateReg == Alert);
  assign busy         = (stateReg != StandBy);
  assign result_valid = validReg;

endmodule
